// File: rtl/johnson_pkg.sv
// Shared definitions for consumers of the 4-bit Johnson counter stream.
package johnson_pkg;

  typedef enum logic [1:0] {ST_ACQ, ST_LOCK, ST_FAULT} state_t;

  localparam logic [7:0] ERR_SAT = 8'hFF;

  function automatic int idx_w(input int w);
    return $clog2(2 * w);
  endfunction

endpackage

// File: rtl/johnson_phase_tracker_if.sv
// Code input and status outputs of the Johnson phase tracker.
interface johnson_phase_tracker_if
  import johnson_pkg::*;
#(
  parameter int W     = 4,
  parameter int REV_W = 8
);
  localparam int IW = idx_w(W);

  logic [W-1:0]     jc;
  logic             clr_fault;
  logic [IW-1:0]    phase_idx;
  logic [2*W-1:0]   phase_oh;
  logic             code_ok;
  logic             locked;
  logic             fault;
  logic             rev_pulse;
  logic [REV_W-1:0] rev_count;
  logic [7:0]       err_cnt;

  modport master (
    output jc, clr_fault,
    input  phase_idx, phase_oh, code_ok, locked, fault, rev_pulse, rev_count, err_cnt
  );

  modport slave (
    input  jc, clr_fault,
    output phase_idx, phase_oh, code_ok, locked, fault, rev_pulse, rev_count, err_cnt
  );
endinterface

// File: rtl/johnson_decode.sv
// Combinational Johnson code decoder: legality, phase index and one-hot phase.
module johnson_decode
  import johnson_pkg::*;
#(
  parameter int W = 4,
  localparam int IW = idx_w(W)
) (
  input  logic [W-1:0]   jc,
  output logic           legal,
  output logic [IW-1:0]  idx,
  output logic [2*W-1:0] oh
);
  localparam logic [W-1:0] ONES = '1;

  // Phases 1..W fill from the MSB; phases W+1..2W-1 drain towards the LSB.
  always_comb begin
    legal = (jc == '0);
    idx   = '0;
    for (int p = 1; p <= W; p++) begin
      if (jc == (ONES << (W - p))) begin
        legal = 1'b1;
        idx   = IW'(p);
      end
      if ((p < W) && (jc == (ONES >> (W - p)))) begin
        legal = 1'b1;
        idx   = IW'(2 * W - p);
      end
    end
    oh = '0;
    if (legal) oh[idx] = 1'b1;
  end

endmodule

// File: rtl/johnson_phase_tracker.sv
// Decodes the Johnson counter stream, checks sequencing, locks on and counts revolutions.
module johnson_phase_tracker
  import johnson_pkg::*;
#(
  parameter int W          = 4,
  parameter int LOCK_CNT   = 2,
  parameter int ALLOW_HOLD = 0,
  parameter int REV_W      = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  johnson_phase_tracker_if.slave  bus
);
  localparam int IW  = idx_w(W);
  localparam int NPH = 2 * W;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == ERR_SAT) ? v : v + 8'd1;
  endfunction

  logic             legal_p0;
  logic [IW-1:0]    idx_p0;
  logic [2*W-1:0]   oh_p0;
  logic [IW-1:0]    prev_idx;
  logic             prev_valid;
  logic [IW-1:0]    next_exp_p0;
  logic             checked_p0, correct_p0, step_err_p0, err_ev_p0, rev_p0;
  logic             locked_c, fault_c;
  state_t           state, state_nx;
  logic [3:0]       match, match_nx;

  logic [IW-1:0]    phase_idx_p1;
  logic [2*W-1:0]   phase_oh_p1;
  logic             code_ok_p1, rev_pulse_p1;
  logic [REV_W-1:0] rev_count_p1;
  logic [7:0]       err_cnt_p1;

  johnson_decode #(.W(W)) u_dec (
    .jc    (bus.jc),
    .legal (legal_p0),
    .idx   (idx_p0),
    .oh    (oh_p0)
  );

  // Stage p0: step check against the previous legal phase.
  assign next_exp_p0 = (prev_idx == IW'(NPH - 1)) ? '0 : prev_idx + 1'b1;
  assign checked_p0  = legal_p0 && prev_valid;
  assign correct_p0  = checked_p0 &&
                       ((idx_p0 == next_exp_p0) || ((ALLOW_HOLD != 0) && (idx_p0 == prev_idx)));
  assign step_err_p0 = checked_p0 && !correct_p0;
  assign err_ev_p0   = !legal_p0 || step_err_p0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_ACQ;
      match <= '0;
    end else begin
      state <= state_nx;
      match <= match_nx;
    end
  end

  always_comb begin
    state_nx = state;
    match_nx = match;
    case (state)
      ST_ACQ: begin
        if (correct_p0) begin
          if (match + 4'd1 == 4'(LOCK_CNT)) begin
            state_nx = ST_LOCK;
            match_nx = '0;
          end else begin
            match_nx = match + 4'd1;
          end
        end else begin
          match_nx = '0;
        end
      end
      ST_LOCK:  if (err_ev_p0) state_nx = ST_FAULT;
      ST_FAULT: begin
        if (bus.clr_fault) begin
          state_nx = ST_ACQ;
          match_nx = '0;
        end
      end
      default:  state_nx = ST_ACQ;
    endcase
  end

  always_comb begin
    locked_c = (state == ST_LOCK);
    fault_c  = (state == ST_FAULT);
    rev_p0   = locked_c && correct_p0 && (prev_idx == IW'(NPH - 1)) && (idx_p0 == '0);
  end

  // Stage p1: registered outputs and history. Illegal codes register index 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_idx     <= '0;
      prev_valid   <= 1'b0;
      phase_idx_p1 <= '0;
      phase_oh_p1  <= '0;
      code_ok_p1   <= 1'b0;
      rev_pulse_p1 <= 1'b0;
      rev_count_p1 <= '0;
      err_cnt_p1   <= '0;
    end else begin
      prev_valid   <= legal_p0;
      if (legal_p0) prev_idx <= idx_p0;
      phase_idx_p1 <= idx_p0;
      phase_oh_p1  <= oh_p0;
      code_ok_p1   <= legal_p0;
      rev_pulse_p1 <= rev_p0;
      if (rev_p0) rev_count_p1 <= rev_count_p1 + 1'b1;
      if (err_ev_p0) err_cnt_p1 <= sat_inc(err_cnt_p1);
    end
  end

  assign bus.phase_idx = phase_idx_p1;
  assign bus.phase_oh  = phase_oh_p1;
  assign bus.code_ok   = code_ok_p1;
  assign bus.locked    = locked_c;
  assign bus.fault     = fault_c;
  assign bus.rev_pulse = rev_pulse_p1;
  assign bus.rev_count = rev_count_p1;
  assign bus.err_cnt   = err_cnt_p1;

endmodule

// File: doc/johnson_phase_tracker.md
Name: johnson_phase_tracker

Overview:
- Sits directly downstream of the team's 4-bit Johnson counter and consumes its code every clock.
- Decodes the code into a phase index and a one-hot phase vector.
- Checks code legality and step-by-step sequencing, and locks onto the stream through a small FSM.
- Counts full revolutions for the multiphase timing logic further down.

Parameters:
- W, 4, Johnson code width; the sequence has 2W phases.
- LOCK_CNT, 2, consecutive correct steps needed to enter LOCK (range 1..15).
- ALLOW_HOLD, 0, if 1, an unchanged legal code counts as a correct step; if 0, it is a step error.
- REV_W, 8, width of the revolution counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- jc  in  W  Johnson code from the upstream counter.
- clr_fault  in  1  single-cycle pulse; leaves FAULT.
- phase_idx  out  $clog2(2W)  decoded phase index, registered.
- phase_oh  out  2W  one-hot phase; all zero when jc is illegal.
- code_ok  out  1  registered jc-legal flag.
- locked  out  1  1 while the FSM is in LOCK.
- fault  out  1  1 while the FSM is in FAULT.
- rev_pulse  out  1  one-cycle pulse on wrap 2W-1 -> 0 while in LOCK.
- rev_count  out  REV_W  revolutions completed in LOCK; wraps modulo 2^REV_W.
- err_cnt  out  8  total illegal-code and step errors; saturates at 255.

Behaviour:
- Reset: phase_idx=0, phase_oh=0, code_ok=0, locked=0, fault=0, rev_pulse=0, rev_count=0, err_cnt=0. FSM enters ACQ, match count=0, prev_idx=0, prev_valid=0.
- Upstream sequence, W=4: 0000,1000,1100,1110,1111,0111,0011,0001, then back to 0000. These are indices 0..7.
- Legal codes:
  - jc==0;
  - MSB=1 with the ones contiguous from the MSB; idx = popcount;
  - MSB=0 with the ones contiguous from the LSB; idx = 2W - popcount.
  - Every other code is illegal.
- Latency: all outputs are registered. jc sampled at edge k appears on the outputs after edge k.
- Step check, evaluated only when the current code is legal and prev_valid=1:
  - correct if idx == (prev_idx+1) mod 2W;
  - a hold (idx == prev_idx) is correct only when ALLOW_HOLD=1;
  - anything else is a step error.
- prev_idx/prev_valid update:
  - on a legal code: prev_idx <= idx, prev_valid <= 1;
  - on an illegal code: prev_valid <= 0, so the next legal code is not step-checked.
- Error event = illegal code OR step error. Each event cycle increments err_cnt by 1, saturating at 255, in every FSM state.
- FSM:
  - ACQ:
    - a correct step increments the match count;
    - an error event or an unchecked legal code clears the match count to 0;
    - when the count reaches LOCK_CNT, go to LOCK and clear the count.
  - LOCK: an error event goes to FAULT; otherwise stay.
  - FAULT: sticky. clr_fault=1 goes to ACQ with the match count cleared.
  - clr_fault outside FAULT is ignored.
- Simultaneous events:
  - clr_fault together with an error event in FAULT still goes to ACQ, and err_cnt still increments;
  - the cycle's correct-step evaluation does not count toward lock.
- Revolutions:
  - condition: in LOCK, correct step, prev_idx=2W-1, idx=0;
  - effect: rev_pulse=1 for one cycle and rev_count+1, wrapping at 2^REV_W.
  - The step that enters LOCK does not count as a revolution.
- Reset mid-operation: immediate asynchronous clear to the reset values above.

Decomposition:
- Shared package johnson_pkg holds:
  - the state enum {ST_ACQ, ST_LOCK, ST_FAULT};
  - a phase-index width function;
  - the err_cnt saturation constant 8'hFF.
- Sub-module johnson_decode (purely combinational): jc -> {legal, idx, one-hot}. It is reused by other Johnson-code consumers.

Test Plan:
- Reset, then drive the legal sequence 0000,1000,1100 -> locked rises 1 cycle after 1100 is sampled; phase_idx=2; phase_oh=8'b00000100.
- Run locked through ...0011,0001,0000 -> rev_pulse high exactly 1 cycle on idx 7->0; rev_count 0->1. Run 256 revolutions -> rev_count wraps to 0.
- While locked, inject 1010 -> code_ok=0, phase_oh=0, fault=1, err_cnt+1. Next 1100 is not step-checked; fault stays 1.
- In FAULT, pulse clr_fault together with a skip 1000->1110 -> FSM goes to ACQ, err_cnt+1. Then 1111,0111 -> locked=1.
- With ALLOW_HOLD=0, hold jc=1100 for 3 cycles while locked -> fault. With ALLOW_HOLD=1, same stimulus -> stays locked, err_cnt unchanged.
- Force 300 illegal codes -> err_cnt saturates at 255. Assert reset asynchronously mid-cycle -> all outputs 0 before the next edge.
